// File: rtl/alu_arb_if.sv
// Request/response bundle between two ALU requesters and the shared arbiter.
// The master side issues operations; the slave side is the arbitrated ALU.
interface alu_arb_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_m0;
  logic [2:0]       req_m1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_cf;
  logic             rsp_of;
  logic             rsp_zf;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1,
    output req_m0, req_m1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y,
    input  rsp_cf, rsp_of, rsp_zf
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1,
    input  req_m0, req_m1, rsp_ready,
    output req_ready, rsp_valid, rsp_y,
    output rsp_cf, rsp_of, rsp_zf
  );
endinterface

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a single-cycle ALU.
// Sequence per op: IDLE (accept) -> EXEC (compute) -> RESP (hold result).
module alu_arb #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       m_q, m_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;

  logic             sel;
  logic [1:0]       rdy;
  logic [1:0]       vld;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cf;
  logic             alu_of;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    sel = ptr_q;
    if (bus.req_valid == 2'b01) sel = 1'b0;
    else if (bus.req_valid == 2'b10) sel = 1'b1;
  end

  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    dif    = {1'b0, a_q} - {1'b0, b_q};
    alu_y  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    unique case (m_q)
      3'b000: begin
        alu_y  = sum[WIDTH-1:0];
        alu_cf = sum[WIDTH];
        alu_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        alu_y  = dif[WIDTH-1:0];
        alu_cf = dif[WIDTH];
        alu_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                 (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010:  alu_y = a_q & b_q;
      3'b011:  alu_y = a_q | b_q;
      3'b100:  alu_y = a_q ^ b_q;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    y_d     = y_q;
    cf_d    = cf_q;
    of_d    = of_q;
    zf_d    = zf_q;
    rdy     = 2'b00;
    vld     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          rdy[sel] = 1'b1;
          own_d    = sel;
          ptr_d    = ~sel;
          a_d      = sel ? bus.req_a1 : bus.req_a0;
          b_d      = sel ? bus.req_b1 : bus.req_b0;
          m_d      = sel ? bus.req_m1 : bus.req_m0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        y_d     = alu_y;
        cf_d    = alu_cf;
        of_d    = alu_of;
        zf_d    = ~|alu_y;
        state_d = RESP;
      end
      RESP: begin
        vld[own_q] = 1'b1;
        if (bus.rsp_ready[own_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
      own_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      y_q   <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      own_q <= own_d;
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      y_q   <= y_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
      zf_q  <= zf_d;
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = vld;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_cf    = cf_q;
  assign bus.rsp_of    = of_q;
  assign bus.rsp_zf    = zf_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: vector table for ALU ops and flags,
// plus hand sequences for round-robin, backpressure and mid-op reset.
module tb_alu_arb;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_arb_if #(.WIDTH(32)) bus ();

  alu_arb #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic [31:0] y;
    logic        cf;
    logic        of;
    logic        zf;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    bus.req_a0 = 32'hDEAD_0000;
    bus.req_b0 = 32'h0000_BEEF;
    bus.req_m0 = 3'b011;
    bus.req_a1 = 32'hCAFE_0000;
    bus.req_b1 = 32'h0000_F00D;
    bus.req_m1 = 3'b100;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input vec_t v);
    logic [1:0] mask;
    mask = v.req ? 2'b10 : 2'b01;
    bus.rsp_ready = 2'b11;
    if (v.req) begin
      bus.req_a1 = v.a; bus.req_b1 = v.b; bus.req_m1 = v.m;
      bus.req_a0 = ~v.a; bus.req_b0 = v.a; bus.req_m0 = 3'b100;
    end else begin
      bus.req_a0 = v.a; bus.req_b0 = v.b; bus.req_m0 = v.m;
      bus.req_a1 = ~v.a; bus.req_b1 = v.a; bus.req_m1 = 3'b100;
    end
    bus.req_valid = mask;
    #1 chk("idle_req_ready", bus.req_ready, mask);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    scramble();
    chk("exec_rsp_valid", bus.rsp_valid, 2'b00);
    @(posedge clk); #1;
    chk("resp_rsp_valid", bus.rsp_valid, mask);
    chk("resp_req_ready", bus.req_ready, 2'b00);
    chk("y", bus.rsp_y, v.y);
    chk("cf", bus.rsp_cf, v.cf);
    chk("of", bus.rsp_of, v.of);
    chk("zf", bus.rsp_zf, v.zf);
    @(posedge clk); #1;
    chk("post_rsp_valid", bus.rsp_valid, 2'b00);
    chk("post_y_hold", bus.rsp_y, v.y);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 32'h7FFFFFFF, 32'd1, 3'b000,
               32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 3'b000,
               32'h0, 1'b1, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 32'd3, 32'd5, 3'b001,
               32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 32'h80000000, 32'd1, 3'b001,
               32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 32'd5, 32'd5, 3'b001, 32'h0, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 32'hF0F000FF, 32'h0FF0F0F0, 3'b010,
               32'h00F000F0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 32'h12000034, 32'h00456700, 3'b011,
               32'h12456734, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 32'hAAAA5555, 32'hAAAA5555, 3'b100,
               32'h0, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 32'd1, 32'd2, 3'b101, 32'h0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111,
               32'h0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000,
               32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 32'd0, 32'd1, 3'b001,
               32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    scramble();
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_y", bus.rsp_y, 32'h0);
    chk("rst_flags", {bus.rsp_cf, bus.rsp_of, bus.rsp_zf}, 3'b000);
    rst = 1'b0;

    // First edge after reset already accepts.
    for (int i = 0; i < 13; i++) do_op(tv[i]);

    // A request withdrawn before the edge leaves no trace.
    bus.req_valid = 2'b01;
    #2 bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("drop_rsp_valid", bus.rsp_valid, 2'b00);
    @(posedge clk); #1;
    chk("drop_rsp_valid2", bus.rsp_valid, 2'b00);
    @(negedge clk);

    // Round-robin under a permanent tie, starting from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_a0 = 32'd10; bus.req_b0 = 32'd1; bus.req_m0 = 3'b001;
    bus.req_a1 = 32'd20; bus.req_b1 = 32'd3; bus.req_m1 = 3'b001;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_grant", bus.req_ready, (i % 2) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      chk("rr_exec", bus.rsp_valid, 2'b00);
      @(posedge clk); #1;
      chk("rr_owner", bus.rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_y", bus.rsp_y, (i % 2) ? 32'd17 : 32'd9);
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;

    // Response backpressure; non-owner ready is ignored.
    bus.req_a1 = 32'd5; bus.req_b1 = 32'd7; bus.req_m1 = 3'b110;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 2'b10);
      chk("bp_y", bus.rsp_y, 32'h0);
      chk("bp_zf", bus.rsp_zf, 1'b1);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    chk("bp_nonowner", bus.rsp_valid, 2'b10);
    chk("bp_done_req_ready", bus.req_ready, 2'b00);
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    chk("bp_idle_rsp_valid", bus.rsp_valid, 2'b00);
    chk("bp_idle_grant", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    @(negedge clk);

    // Reset while holding a response: it must vanish for good.
    bus.req_a0 = 32'd1; bus.req_b0 = 32'd1; bus.req_m0 = 3'b000;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("mr_resp", bus.rsp_valid, 2'b01);
    chk("mr_y", bus.rsp_y, 32'd2);
    rst = 1'b1;
    #1;
    chk("mr_drop", bus.rsp_valid, 2'b00);
    chk("mr_y_clr", bus.rsp_y, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mr_silent", bus.rsp_valid, 2'b00);
    end
    @(negedge clk);
    bus.req_a0 = 32'd4; bus.req_b0 = 32'd4;
    bus.req_a1 = 32'd9; bus.req_b1 = 32'd9; bus.req_m1 = 3'b000;
    bus.req_valid = 2'b11;
    #1 chk("mr_tie_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("mr_new_rsp", bus.rsp_valid, 2'b01);
    chk("mr_new_y", bus.rsp_y, 32'd8);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
